// File: rtl/logarithmic_afpm.sv
// ---------------------------------------------------------------------------
// logarithmic_afpm
//
// Approximate FP16 (IEEE-754 binary16) multiplier based on Mitchell's
// logarithmic approximation: exponents and significands are added, so the
// fractional parts are summed instead of multiplied. The block sits behind
// an 8-bit pin interface. Operands are loaded low byte first, and the product
// is returned low byte first. Each operation takes a fixed five-phase frame:
//     LD_LO -> LD_HI -> CALC -> OUT_LO -> OUT_HI -> LD_LO ...
//
// Ports
//     clk      : system clock, all state updates on the rising edge
//     rst      : synchronous reset, active high, takes effect even when ena=0
//     ena      : clock enable, 0 freezes every register
//     ui_in    : operand A byte (low byte in LD_LO, high byte in LD_HI)
//     uio_in   : operand B byte (same phasing as ui_in)
//     uo_out   : result byte, registered (R[7:0] after OUT_LO, R[15:8] after OUT_HI)
//     uio_out  : constant 8'h00
//     uio_oe   : constant 8'h00 (uio pins are always inputs)
// ---------------------------------------------------------------------------
module logarithmic_afpm (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        ST_LD_LO  = 3'd0,
        ST_LD_HI  = 3'd1,
        ST_CALC   = 3'd2,
        ST_OUT_LO = 3'd3,
        ST_OUT_HI = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_r;
    logic [7:0]  r_out;
    logic [15:0] w_product;

    // Mitchell product of two FP16 values. Subnormals are flushed to zero,
    // and the result is truncated because no rounding is applied.
    function automatic logic [15:0] mitchell_mul(input logic [15:0] a,
                                                 input logic [15:0] b);
        logic              s;
        logic [4:0]        ea;
        logic [4:0]        eb;
        logic [9:0]        ma;
        logic [9:0]        mb;
        logic [10:0]       msum;
        logic signed [7:0] e_sum;
        logic              a_nan;
        logic              b_nan;
        logic              a_inf;
        logic              b_inf;
        logic              a_zero;
        logic              b_zero;
        logic [15:0]       res;

        s      = a[15] ^ b[15];
        ea     = a[14:10];
        eb     = b[14:10];
        ma     = a[9:0];
        mb     = b[9:0];
        a_nan  = (ea == 5'h1F) && (ma != 10'h000);
        b_nan  = (eb == 5'h1F) && (mb != 10'h000);
        a_inf  = (ea == 5'h1F) && (ma == 10'h000);
        b_inf  = (eb == 5'h1F) && (mb == 10'h000);
        a_zero = (ea == 5'h00);
        b_zero = (eb == 5'h00);

        msum   = {1'b0, ma} + {1'b0, mb};
        // A carry out of the fraction sum becomes an exponent increment in
        // the antilog step. The fraction keeps only the low 10 bits.
        e_sum  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15
                 + $signed({7'b0000000, msum[10]});

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res = 16'h7E00;
        end else if (a_inf || b_inf) begin
            res = {s, 5'h1F, 10'h000};
        end else if (a_zero || b_zero) begin
            res = {s, 15'h0000};
        end else if (e_sum >= 8'sd31) begin
            res = {s, 5'h1F, 10'h000};
        end else if (e_sum <= 8'sd0) begin
            res = {s, 15'h0000};
        end else begin
            res = {s, e_sum[4:0], msum[9:0]};
        end
        return res;
    endfunction

    assign w_product = mitchell_mul(r_a, r_b);
    assign uo_out    = r_out;
    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;

    // Phase register: advances one phase per enabled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LD_LO;
        end else if (ena) begin
            r_state <= w_next_state;
        end
    end

    // Next-phase selection for the fixed five-phase frame.
    always_comb begin
        w_next_state = ST_LD_LO;
        case (r_state)
            ST_LD_LO:  w_next_state = ST_LD_HI;
            ST_LD_HI:  w_next_state = ST_CALC;
            ST_CALC:   w_next_state = ST_OUT_LO;
            ST_OUT_LO: w_next_state = ST_OUT_HI;
            ST_OUT_HI: w_next_state = ST_LD_LO;
            default:   w_next_state = ST_LD_LO;
        endcase
    end

    // Operand capture, result latch and output byte, selected by phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= 16'h0000;
            r_b   <= 16'h0000;
            r_r   <= 16'h0000;
            r_out <= 8'h00;
        end else if (ena) begin
            case (r_state)
                ST_LD_LO: begin
                    r_a[7:0] <= ui_in;
                    r_b[7:0] <= uio_in;
                end
                ST_LD_HI: begin
                    r_a[15:8] <= ui_in;
                    r_b[15:8] <= uio_in;
                end
                ST_CALC:   r_r   <= w_product;
                ST_OUT_LO: r_out <= r_r[7:0];
                ST_OUT_HI: r_out <= r_r[15:8];
                default:   r_out <= r_out;
            endcase
        end
    end

endmodule

// File: tb/tb_logarithmic_afpm.sv
module tb_logarithmic_afpm;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int          total = 0;
    int          bad   = 0;
    int unsigned edge_cnt = 0;

    typedef struct {
        int unsigned at_edge;
        logic [7:0]  val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logarithmic_afpm dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference: log2(x) ~ (e - 15) + m/1024; add the logs, then take the
    // antilog with the fractional part used directly as the significand.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, frac_sum, log_int, biased;
        bit sgn, nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
        logic [15:0] res;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = int'(a[9:0]);   mb = int'(b[9:0]);
        sgn   = a[15] ^ b[15];
        nan_a = (ea == 31) && (ma != 0);
        nan_b = (eb == 31) && (mb != 0);
        inf_a = (ea == 31) && (ma == 0);
        inf_b = (eb == 31) && (mb == 0);
        zer_a = (ea == 0);
        zer_b = (eb == 0);
        if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a)) return 16'h7E00;
        if (inf_a || inf_b) begin
            res = 16'h7C00; res[15] = sgn; return res;
        end
        if (zer_a || zer_b) begin
            res = 16'h0000; res[15] = sgn; return res;
        end
        frac_sum = ma + mb;
        log_int  = (ea - 15) + (eb - 15) + (frac_sum / 1024);
        biased   = log_int + 15;
        if (biased >= 31) begin
            res = 16'h7C00; res[15] = sgn; return res;
        end
        if (biased <= 0) begin
            res = 16'h0000; res[15] = sgn; return res;
        end
        res = 16'h0000;
        res[15]    = sgn;
        res[14:10] = 5'(biased);
        res[9:0]   = 10'(frac_sum % 1024);
        return res;
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 9))
            0:       v[14:10] = 5'd0;
            1:       begin v[14:10] = 5'd31; v[9:0] = 10'd0; end
            2:       begin v[14:10] = 5'd31; v[0] = 1'b1; end
            3:       v[14:10] = 5'($urandom_range(28, 30));
            4:       v[14:10] = 5'($urandom_range(1, 5));
            default: v[14:10] = 5'($urandom_range(1, 30));
        endcase
        return v;
    endfunction

    task automatic push(input int unsigned at, input logic [7:0] v, input string tag);
        exp_t e;
        e.at_edge = at; e.val = v; e.tag = tag;
        sb_q.push_back(e);
    endtask

    // One enabled-or-not clock edge with the given bytes on the pins.
    task automatic drive(input logic [7:0] a, input logic [7:0] b);
        ui_in = a; uio_in = b;
        @(negedge clk);
    endtask

    // Full frame; optionally ena drops for 'freeze' edges right after OUT_LO.
    task automatic frame(input logic [15:0] a, input logic [15:0] b,
                         input int freeze, input string name);
        int unsigned k;
        logic [15:0] r;
        k = edge_cnt + 1;
        r = ref_mul(a, b);
        push(k + 3, r[7:0], $sformatf("%s_lo a=%h b=%h", name, a, b));
        for (int i = 1; i <= freeze; i++)
            push(k + 3 + i, r[7:0], $sformatf("%s_frozen%0d", name, i));
        push(k + 4 + freeze, r[15:8], $sformatf("%s_hi a=%h b=%h", name, a, b));
        push(k + 6 + freeze, r[15:8], $sformatf("%s_hold", name));
        ena = 1'b1;
        drive(a[7:0], b[7:0]);
        drive(a[15:8], b[15:8]);
        drive(8'($urandom), 8'($urandom));
        drive(8'($urandom), 8'($urandom));
        if (freeze > 0) begin
            ena = 1'b0;
            repeat (freeze) drive(8'($urandom), 8'($urandom));
            ena = 1'b1;
        end
        drive(8'($urandom), 8'($urandom));
    endtask

    // Load an operand pair, then reset during CALC; output must stay zero.
    task automatic reset_frame(input logic [15:0] a, input logic [15:0] b);
        int unsigned k;
        k = edge_cnt + 1;
        for (int i = 2; i <= 5; i++)
            push(k + i, 8'h00, $sformatf("rst_calc_zero%0d", i));
        ena = 1'b1;
        drive(a[7:0], b[7:0]);
        drive(a[15:8], b[15:8]);
        rst = 1'b1;
        drive(8'($urandom), 8'($urandom));
        rst = 1'b0;
    endtask

    // Monitor: pop every expectation whose edge has passed and compare.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].at_edge <= edge_cnt) begin
            mon_e = sb_q.pop_front();
            total++;
            if (mon_e.at_edge < edge_cnt) begin
                bad++;
                $display("FAIL %s: expectation for edge %0d missed at edge %0d",
                         mon_e.tag, mon_e.at_edge, edge_cnt);
            end else if ({uio_oe, uio_out, uo_out} !== {16'h0000, mon_e.val}) begin
                bad++;
                $display("FAIL %s: got uo_out=%h uio_out=%h uio_oe=%h, expected uo_out=%h uio=00/00",
                         mon_e.tag, uo_out, uio_out, uio_oe, mon_e.val);
            end
        end
    end

    initial begin
        int unsigned k;
        rst = 1'b1; ena = 1'b0; ui_in = 8'h55; uio_in = 8'hAA;
        @(negedge clk);
        k = edge_cnt + 1;
        for (int i = 0; i < 3; i++) push(k + i, 8'h00, $sformatf("reset%0d", i));
        drive(8'h55, 8'hAA);
        drive(8'h55, 8'hAA);
        rst = 1'b0;
        drive(8'h55, 8'hAA);

        frame(16'h3E00, 16'h4200, 0, "p1_5x3");
        frame(16'h3D00, 16'h3D00, 0, "p1_25sq");
        frame(16'h3C00, 16'hC000, 0, "neg2");
        frame(16'h8000, 16'h4200, 0, "negzero");
        frame(16'h0001, 16'h3C00, 0, "subnorm");
        frame(16'h7BFF, 16'h7BFF, 0, "overflow");
        frame(16'h0400, 16'h0400, 0, "underflow");
        frame(16'h7C00, 16'h0000, 0, "inf_x_zero");
        frame(16'hFC00, 16'h3C00, 0, "neg_inf");
        frame(16'h7E01, 16'h3C00, 0, "nan");
        frame(16'h4500, 16'h4600, 3, "freeze");
        frame(16'h3555, 16'hB2AA, 0, "post_freeze");
        reset_frame(16'h4000, 16'h4000);
        frame(16'h4100, 16'h4300, 0, "post_reset");

        for (int n = 0; n < 60; n++)
            frame(rand_op(), rand_op(), 0, $sformatf("rnd%0d", n));
        frame(16'h0000, 16'h0000, 0, "tail");
        repeat (4) @(negedge clk);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
